// File: rtl/ws281x_pkg.sv
// Shared types and helpers for the WS281x pulse-code receiver.
package ws281x_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } ws281x_rx_state_t;

  localparam int BYTE_BITS = 8;

  // Bits arrive MSB first, so each new bit enters at the LSB end.
  function automatic logic [BYTE_BITS-1:0] shift_in(input logic [BYTE_BITS-1:0] sr,
                                                     input logic b);
    return {sr[BYTE_BITS-2:0], b};
  endfunction

endpackage

// File: rtl/ws281x_recv_if.sv
// Line, threshold and decoded-output bundle between the pin side and the receiver.
interface ws281x_recv_if #(
  parameter int HCNT_WIDTH = 8,
  parameter int LCNT_WIDTH = 16
);
  logic                  code_in;
  logic [HCNT_WIDTH-1:0] thr_cnt_in;
  logic [HCNT_WIDTH-1:0] min_cnt_in;
  logic [LCNT_WIDTH-1:0] rst_cnt_in;
  logic                  bit_rdy_out;
  logic                  bit_data_out;
  logic                  byte_rdy_out;
  logic [7:0]            byte_data_out;
  logic                  frame_done_out;
  logic                  err_out;

  modport master (
    output code_in, thr_cnt_in, min_cnt_in, rst_cnt_in,
    input  bit_rdy_out, bit_data_out, byte_rdy_out, byte_data_out,
           frame_done_out, err_out
  );

  modport slave (
    input  code_in, thr_cnt_in, min_cnt_in, rst_cnt_in,
    output bit_rdy_out, bit_data_out, byte_rdy_out, byte_data_out,
           frame_done_out, err_out
  );
endinterface

// File: rtl/ws281x_sync.sv
// Synchronizer for the asynchronous code line plus a one-flop edge detector.
module ws281x_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic code_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Shift the raw line through the synchronizer, then keep one delayed copy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], code_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/ws281x_recv.sv
// WS281x NRZ receiver: times high pulses, classifies bits, packs bytes, spots frame reset.
//
// state | meaning
// IDLE  | line low after reset or frame end, waiting for first rising edge
// HIGH  | timing a high pulse in h_cnt
// LOW   | timing the low gap in l_cnt, looking for next rise or frame reset
// STUCK | high pulse overran the counter; discard until the line falls
module ws281x_recv
  import ws281x_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HCNT_WIDTH  = 8,
  parameter int LCNT_WIDTH  = 16
) (
  input logic           clk_in,
  input logic           rst_n_in,
  ws281x_recv_if.slave  bus
);
  localparam logic [HCNT_WIDTH-1:0] H_MAX = '1;
  localparam logic [LCNT_WIDTH-1:0] L_MAX = '1;
  localparam logic [HCNT_WIDTH-1:0] H_ONE = HCNT_WIDTH'(1);
  localparam logic [LCNT_WIDTH-1:0] L_ONE = LCNT_WIDTH'(1);

  logic line_lvl;
  logic line_rise;
  logic line_fall;

  ws281x_rx_state_t      state_q;
  logic [HCNT_WIDTH-1:0] h_cnt_q;
  logic [LCNT_WIDTH-1:0] l_cnt_q;
  logic [2:0]            bit_idx_q;
  logic [7:0]            shift_q;

  logic                  bit_rdy_q;
  logic                  bit_data_q;
  logic                  byte_rdy_q;
  logic [7:0]            byte_data_q;
  logic                  frame_done_q;
  logic                  err_q;

  logic                  new_bit;
  logic [7:0]            next_shift;

  ws281x_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .code_in  (bus.code_in),
    .level    (line_lvl),
    .rise     (line_rise),
    .fall     (line_fall)
  );

  // The bit is judged on the completed high time, before any further increment.
  assign new_bit    = (h_cnt_q > bus.thr_cnt_in);
  assign next_shift = shift_in(shift_q, new_bit);

  // Receiver FSM with its counters, bit assembly and registered output pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      h_cnt_q      <= '0;
      l_cnt_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      bit_rdy_q    <= 1'b0;
      bit_data_q   <= 1'b0;
      byte_rdy_q   <= 1'b0;
      byte_data_q  <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      bit_rdy_q    <= 1'b0;
      byte_rdy_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;

      case (state_q)
        IDLE: begin
          if (line_rise) begin
            h_cnt_q <= H_ONE;
            state_q <= HIGH;
          end
        end

        HIGH: begin
          if (h_cnt_q == H_MAX) begin
            // Overlong pulse: flag once and drop the partial byte alignment.
            err_q     <= 1'b1;
            bit_idx_q <= '0;
            if (line_fall) begin
              l_cnt_q <= L_ONE;
              state_q <= LOW;
            end else begin
              state_q <= STUCK;
            end
          end else if (line_fall) begin
            l_cnt_q <= L_ONE;
            state_q <= LOW;
            if (h_cnt_q < bus.min_cnt_in) begin
              err_q <= 1'b1;
            end else begin
              bit_rdy_q  <= 1'b1;
              bit_data_q <= new_bit;
              shift_q    <= next_shift;
              bit_idx_q  <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                byte_rdy_q  <= 1'b1;
                byte_data_q <= next_shift;
              end
            end
          end else begin
            h_cnt_q <= h_cnt_q + H_ONE;
          end
        end

        STUCK: begin
          if (line_fall) begin
            l_cnt_q <= L_ONE;
            state_q <= LOW;
          end
        end

        LOW: begin
          if (line_rise) begin
            h_cnt_q <= H_ONE;
            state_q <= HIGH;
          end else if (!line_lvl && (l_cnt_q == bus.rst_cnt_in)) begin
            // l_cnt is never 0 here, so a zero threshold never ends a frame.
            frame_done_q <= 1'b1;
            err_q        <= (bit_idx_q != 3'd0);
            bit_idx_q    <= '0;
            shift_q      <= '0;
            state_q      <= IDLE;
          end else if (l_cnt_q != L_MAX) begin
            l_cnt_q <= l_cnt_q + L_ONE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bit_rdy_out    = bit_rdy_q;
  assign bus.bit_data_out   = bit_data_q;
  assign bus.byte_rdy_out   = byte_rdy_q;
  assign bus.byte_data_out  = byte_data_q;
  assign bus.frame_done_out = frame_done_q;
  assign bus.err_out        = err_q;

endmodule
